core_if_pcgen: RTL and testbench

Fetch-PC generator and single-entry fetch buffer for the IF stage. Holds the architectural fetch PC, issues one instruction-memory request at a time, and captures the response into a holding register. The held PC and instruction drive the pre-decoder and static branch predictor; their verdict (`bju_pc_bj_predict`, `bju_pc_offset`) selects the next fetch PC. EXU redirects on mispredict or `jalr` override everything.

---
 rtl/core_if_pcgen_pkg.sv | 10 +
 rtl/core_if_pcgen.sv | 99 +++++++++
 tb/tb_core_if_pcgen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/core_if_pcgen_pkg.sv
// Shared core-wide widths and encodings used by the IF-stage fetch-PC generator.
package core_if_pcgen_pkg;

    localparam int CORE_PC_WIDTH = 32;
    localparam int CORE_XLEN     = 32;

    // addi x0, x0, 0
    localparam logic [31:0] CORE_NOP = 32'h0000_0013;

endpackage

// File: rtl/core_if_pcgen.sv
// Fetch-PC generator with a single-entry fetch buffer: one outstanding request,
// held instruction offered to ID, next PC chosen by the static predictor or an EXU redirect.
module core_if_pcgen
    import core_if_pcgen_pkg::*;
#(
    parameter logic [CORE_PC_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ifu_req_valid,
    input  logic                     ifu_req_ready,
    output logic [CORE_PC_WIDTH-1:0] ifu_req_pc,
    input  logic                     ifu_rsp_valid,
    input  logic [31:0]              ifu_rsp_inst,
    output logic [CORE_PC_WIDTH-1:0] current_pc,
    output logic [31:0]              current_inst,
    input  logic                     bju_pc_bj_predict,
    input  logic [CORE_PC_WIDTH-1:0] bju_pc_offset,
    input  logic                     exu_redirect_valid,
    input  logic [CORE_PC_WIDTH-1:0] exu_redirect_pc,
    output logic                     if_out_valid,
    input  logic                     if_out_ready,
    output logic                     if_out_pred_taken
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and the payload is held stable until the transfer.
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                   state_q;
    logic [CORE_PC_WIDTH-1:0] pc_q;
    logic                     drop_q;
    logic [CORE_PC_WIDTH-1:0] hold_pc_q;
    logic [31:0]              hold_inst_q;
    logic [CORE_PC_WIDTH-1:0] next_pc;

    assign next_pc = hold_pc_q + (bju_pc_bj_predict ? bju_pc_offset : CORE_PC_WIDTH'(4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            hold_pc_q   <= RESET_PC;
            hold_inst_q <= CORE_NOP;
        end else begin
            case (state_q)
                S_BOOT: state_q <= S_REQ;
                S_REQ: begin
                    if (exu_redirect_valid) pc_q <= exu_redirect_pc;
                    // A request issued alongside a redirect fetched the old path.
                    if (ifu_req_ready) begin
                        state_q <= S_WAIT;
                        drop_q  <= exu_redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (ifu_rsp_valid) begin
                        drop_q <= 1'b0;
                        if (!drop_q && !exu_redirect_valid) begin
                            hold_pc_q   <= pc_q;
                            hold_inst_q <= ifu_rsp_inst;
                            state_q     <= S_HOLD;
                        end else begin
                            if (exu_redirect_valid) pc_q <= exu_redirect_pc;
                            state_q <= S_REQ;
                        end
                    end else if (exu_redirect_valid) begin
                        drop_q <= 1'b1;
                        pc_q   <= exu_redirect_pc;
                    end
                end
                S_HOLD: begin
                    if (exu_redirect_valid) begin
                        pc_q    <= exu_redirect_pc;
                        state_q <= S_REQ;
                    end else if (if_out_ready) begin
                        pc_q    <= next_pc;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end

    assign ifu_req_valid     = (state_q == S_REQ);
    assign ifu_req_pc        = pc_q;
    assign current_pc        = hold_pc_q;
    assign current_inst      = hold_inst_q;
    assign if_out_valid      = (state_q == S_HOLD) && !exu_redirect_valid;
    assign if_out_pred_taken = if_out_valid && bju_pc_bj_predict;

endmodule

// File: tb/tb_core_if_pcgen.sv
// Directed bench for core_if_pcgen: the bench plays instruction memory and ID,
// and every expected value is a hand-computed constant.
module tb_core_if_pcgen;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst;
    logic [31:0] current_pc;
    logic [31:0] current_inst;
    logic        bju_pc_bj_predict;
    logic [31:0] bju_pc_offset;
    logic        exu_redirect_valid;
    logic [31:0] exu_redirect_pc;
    logic        if_out_valid;
    logic        if_out_ready;
    logic        if_out_pred_taken;

    int checks = 0;
    int errors = 0;

    core_if_pcgen #(.RESET_PC(32'h8000_0000)) dut (
        .clk                (clk),
        .rst                (rst),
        .ifu_req_valid      (ifu_req_valid),
        .ifu_req_ready      (ifu_req_ready),
        .ifu_req_pc         (ifu_req_pc),
        .ifu_rsp_valid      (ifu_rsp_valid),
        .ifu_rsp_inst       (ifu_rsp_inst),
        .current_pc         (current_pc),
        .current_inst       (current_inst),
        .bju_pc_bj_predict  (bju_pc_bj_predict),
        .bju_pc_offset      (bju_pc_offset),
        .exu_redirect_valid (exu_redirect_valid),
        .exu_redirect_pc    (exu_redirect_pc),
        .if_out_valid       (if_out_valid),
        .if_out_ready       (if_out_ready),
        .if_out_pred_taken  (if_out_pred_taken)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(ifu_req_valid), 32'd0);
        check({tag, "_out_valid"}, 32'(if_out_valid), 32'd0);
        check({tag, "_pred"}, 32'(if_out_pred_taken), 32'd0);
        check({tag, "_req_pc"}, ifu_req_pc, 32'h8000_0000);
    endtask

    // Called in REQ with ready high: issue, respond next cycle, land in HOLD.
    task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check({tag, "_req_valid"}, 32'(ifu_req_valid), 32'd1);
        check({tag, "_req_pc"}, ifu_req_pc, pc);
        tick();
        check({tag, "_wait_out_valid"}, 32'(if_out_valid), 32'd0);
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = inst;
        tick();
        ifu_rsp_valid = 1'b0;
        check({tag, "_out_valid"}, 32'(if_out_valid), 32'd1);
        check({tag, "_cur_pc"}, current_pc, pc);
        check({tag, "_cur_inst"}, current_inst, inst);
        check({tag, "_hold_req_valid"}, 32'(ifu_req_valid), 32'd0);
    endtask

    task automatic accept(input string tag, input logic pred, input logic [31:0] offset);
        bju_pc_bj_predict = pred;
        bju_pc_offset     = offset;
        if_out_ready      = 1'b1;
        #1;
        check({tag, "_pred_taken"}, 32'(if_out_pred_taken), 32'(pred));
        tick();
        if_out_ready      = 1'b0;
        bju_pc_bj_predict = 1'b0;
        bju_pc_offset     = 32'h0;
    endtask

    initial begin
        rst                = 1'b1;
        ifu_req_ready      = 1'b1;
        ifu_rsp_valid      = 1'b0;
        ifu_rsp_inst       = 32'h0;
        bju_pc_bj_predict  = 1'b0;
        bju_pc_offset      = 32'h0;
        exu_redirect_valid = 1'b0;
        exu_redirect_pc    = 32'h0;
        if_out_ready       = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        check("rst_cur_pc", current_pc, 32'h8000_0000);
        check("rst_cur_inst", current_inst, 32'h0000_0013);

        // Reset release: one BOOT cycle, then the first request.
        rst = 1'b0;
        #1;
        check("boot_req_valid", 32'(ifu_req_valid), 32'd0);
        tick();
        fetch("f0", 32'h8000_0000, 32'h0000_0013);
        accept("a0", 1'b0, 32'h0);

        // Sequential, then a forward and a backward predicted branch.
        fetch("f1", 32'h8000_0004, 32'h00c0_006f);
        accept("a1", 1'b1, 32'h0000_000c);
        fetch("f2", 32'h8000_0010, 32'hfe00_0ce3);
        accept("a2", 1'b1, 32'hffff_fff8);

        // Redirect during WAIT, stale response a cycle later.
        check("rdw_req_pc", ifu_req_pc, 32'h8000_0008);
        tick();
        exu_redirect_valid = 1'b1;
        exu_redirect_pc    = 32'h8000_0100;
        tick();
        exu_redirect_valid = 1'b0;
        ifu_rsp_valid      = 1'b1;
        ifu_rsp_inst       = 32'h1111_1111;
        #1;
        check("rdw_rsp_out_valid", 32'(if_out_valid), 32'd0);
        tick();
        ifu_rsp_valid = 1'b0;
        check("rdw_after_out_valid", 32'(if_out_valid), 32'd0);

        // Redirect on the same edge as the request handshake.
        check("rdh_req_valid", 32'(ifu_req_valid), 32'd1);
        check("rdh_req_pc", ifu_req_pc, 32'h8000_0100);
        exu_redirect_valid = 1'b1;
        exu_redirect_pc    = 32'h8000_0200;
        tick();
        exu_redirect_valid = 1'b0;
        ifu_rsp_valid      = 1'b1;
        ifu_rsp_inst       = 32'h2222_2222;
        tick();
        ifu_rsp_valid = 1'b0;
        check("rdh_out_valid", 32'(if_out_valid), 32'd0);

        // HOLD without acceptance; redirect in the third cycle.
        fetch("f3", 32'h8000_0200, 32'h0010_0093);
        for (int i = 1; i <= 2; i++) begin
            tick();
            check("stall_out_valid", 32'(if_out_valid), 32'd1);
            check("stall_cur_pc", current_pc, 32'h8000_0200);
            check("stall_cur_inst", current_inst, 32'h0010_0093);
        end
        exu_redirect_valid = 1'b1;
        exu_redirect_pc    = 32'h8000_0300;
        #1;
        check("stall_rd_out_valid", 32'(if_out_valid), 32'd0);
        check("stall_rd_pred", 32'(if_out_pred_taken), 32'd0);
        tick();
        exu_redirect_valid = 1'b0;

        // Memory not ready, then asynchronous reset mid-wait.
        ifu_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("nrdy_req_valid", 32'(ifu_req_valid), 32'd1);
            check("nrdy_req_pc", ifu_req_pc, 32'h8000_0300);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        tick();
        rst           = 1'b0;
        ifu_req_ready = 1'b1;
        #1;
        check("arst_boot_req_valid", 32'(ifu_req_valid), 32'd0);
        tick();
        check("arst_req_valid", 32'(ifu_req_valid), 32'd1);
        check("arst_req_pc", ifu_req_pc, 32'h8000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
